// File: rtl/full_logic_pkg.sv
// Shared types and helpers for the full_logic_nch datapath: FSM state encoding,
// a constant-safe log2 and the almost-full threshold clamp.
package full_logic_pkg;

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        INIT   = 3'd1,
        IDLE   = 3'd2,
        ACTIVE = 3'd3,
        ERROR  = 3'd4
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // A zero or out-of-range threshold means "only when completely full".
    function automatic int clamp_thr(input int value, input int depth);
        return ((value == 0) || (value > depth)) ? depth : value;
    endfunction

endpackage

// File: rtl/full_logic_nch_if.sv
// Control/data bundle of full_logic_nch. Statistics signals exist only when
// FULL_LOGIC_STATS_EN is defined.
interface full_logic_nch_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_CH     = 4
);
    logic                         init;
    logic                         wr_enable;
    logic [DATA_WIDTH-1:0]        data_in;
    logic [ADDR_WIDTH:0]          umbral_main;
    logic [ADDR_WIDTH:0]          umbral_ch;
    logic [NUM_CH-1:0]            pop;
    logic [NUM_CH*DATA_WIDTH-1:0] data_out;
    logic [NUM_CH-1:0]            valid_out;
    logic [NUM_CH-1:0]            empty_ch;
    logic [NUM_CH-1:0]            error_ch;
    logic                         main_almost_full;
    logic                         idle_out;
    logic                         active_out;
    logic                         error_out;
`ifdef FULL_LOGIC_STATS_EN
    logic [NUM_CH*16-1:0]         stat_words;
    logic [15:0]                  stat_drops;
`endif

    modport master (
        output init, wr_enable, data_in, umbral_main, umbral_ch, pop,
`ifdef FULL_LOGIC_STATS_EN
        input  stat_words, stat_drops,
`endif
        input  data_out, valid_out, empty_ch, error_ch, main_almost_full,
        input  idle_out, active_out, error_out
    );

    modport slave (
        input  init, wr_enable, data_in, umbral_main, umbral_ch, pop,
`ifdef FULL_LOGIC_STATS_EN
        output stat_words, stat_drops,
`endif
        output data_out, valid_out, empty_ch, error_ch, main_almost_full,
        output idle_out, active_out, error_out
    );
endinterface

// File: rtl/full_logic_nch_fifo.sv
// fifo_sync: single-clock FIFO whose registered read port always presents the
// current head word (first-word fall-through), so consumers can peek at it.
module fifo_sync #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
        wptr_d  = do_push ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The slot being written becomes the head only when the FIFO drains to it.
        rdata_d = (do_push && (wptr_q == rptr_d)) ? wdata : mem[rptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/full_logic_nch.sv
// full_logic_nch: one ingress FIFO routed by a selector field into NUM_CH
// destination FIFOs. Per-channel statistics are built with FULL_LOGIC_STATS_EN.
module full_logic_nch
    import full_logic_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_CH     = 4,
    parameter int SEL_LSB    = 4
) (
    input logic          clk,
    input logic          reset,
    full_logic_nch_if.slave bus
);
    localparam int CH_BITS = clog2(NUM_CH);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int CW      = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         thr_main_q, thr_main_d, thr_ch_q, thr_ch_d;
    logic                  idle_q, idle_d, active_q, active_d, error_q, error_d;
    logic [NUM_CH-1:0]     err_ch_q, err_ch_d, valid_q, valid_d;
    logic [DATA_WIDTH-1:0] dout_q [NUM_CH];
    logic [DATA_WIDTH-1:0] dout_d [NUM_CH];

    logic                  in_push, in_empty, in_full, xfer, overflow, any_data, push_window;
    logic [DATA_WIDTH-1:0] in_head;
    logic [CW-1:0]         in_count;
    logic [CH_BITS-1:0]    target;
    logic [NUM_CH-1:0]     ch_push, ch_pop, ch_empty, ch_full;
    logic [DATA_WIDTH-1:0] ch_head  [NUM_CH];
    logic [CW-1:0]         ch_count [NUM_CH];
    logic [NUM_CH*DATA_WIDTH-1:0] data_out_flat;

    fifo_sync #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ingress (
        .clk(clk), .rst_n(reset), .push(in_push), .pop(xfer), .wdata(bus.data_in),
        .rdata(in_head), .count(in_count), .empty(in_empty), .full(in_full)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fifo_sync #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
            .clk(clk), .rst_n(reset), .push(ch_push[g]), .pop(ch_pop[g]), .wdata(in_head),
            .rdata(ch_head[g]), .count(ch_count[g]), .empty(ch_empty[g]), .full(ch_full[g])
        );
    end

    // Strict head-of-line routing: a blocked head word stalls every channel.
    always_comb begin
        target      = in_head[SEL_LSB +: CH_BITS];
        push_window = (state_q == IDLE) || (state_q == ACTIVE);
        xfer        = (state_q == ACTIVE) && !in_empty &&
                      (ch_count[target] < thr_ch_q) && !ch_full[target];
        in_push     = push_window && bus.wr_enable && (!in_full || xfer);
        overflow    = push_window && bus.wr_enable && in_full && !xfer;
        ch_push     = '0;
        if (xfer) ch_push[target] = 1'b1;
        ch_pop      = (state_q != RESET) ? (bus.pop & ~ch_empty) : '0;
        any_data    = !in_empty || (ch_empty != '1);
    end

    always_comb begin
        state_d    = state_q;
        thr_main_d = thr_main_q;
        thr_ch_d   = thr_ch_q;
        case (state_q)
            RESET: state_d = INIT;
            INIT: begin
                if (bus.init) begin
                    thr_main_d = CW'(clamp_thr(int'(bus.umbral_main), DEPTH));
                    thr_ch_d   = CW'(clamp_thr(int'(bus.umbral_ch), DEPTH));
                end else begin
                    state_d = IDLE;
                end
            end
            IDLE, ACTIVE: begin
                if (overflow)                 state_d = ERROR;
                else if (bus.init)            state_d = INIT;
                else if (any_data || in_push) state_d = ACTIVE;
                else                          state_d = IDLE;
            end
            ERROR:   state_d = ERROR;
            default: state_d = RESET;
        endcase
        idle_d   = (state_d == IDLE);
        active_d = (state_d == ACTIVE);
        error_d  = (state_d == ERROR);
        err_ch_d = err_ch_q | ((state_q != RESET) ? (bus.pop & ch_empty) : '0);
        valid_d  = ch_pop;
        for (int i = 0; i < NUM_CH; i++) begin
            dout_d[i] = ch_pop[i] ? ch_head[i] : dout_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RESET;
            thr_main_q <= CW'(DEPTH);
            thr_ch_q   <= CW'(DEPTH);
            idle_q     <= 1'b0;
            active_q   <= 1'b0;
            error_q    <= 1'b0;
            err_ch_q   <= '0;
            valid_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) dout_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            thr_main_q <= thr_main_d;
            thr_ch_q   <= thr_ch_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
            error_q    <= error_d;
            err_ch_q   <= err_ch_d;
            valid_q    <= valid_d;
            for (int i = 0; i < NUM_CH; i++) dout_q[i] <= dout_d[i];
        end
    end

    always_comb begin
        data_out_flat = '0;
        for (int i = 0; i < NUM_CH; i++) data_out_flat[i*DATA_WIDTH +: DATA_WIDTH] = dout_q[i];
    end

    assign bus.data_out         = data_out_flat;
    assign bus.valid_out        = valid_q;
    assign bus.empty_ch         = ch_empty;
    assign bus.error_ch         = err_ch_q;
    assign bus.main_almost_full = (in_count >= thr_main_q);
    assign bus.idle_out         = idle_q;
    assign bus.active_out       = active_q;
    assign bus.error_out        = error_q;

`ifdef FULL_LOGIC_STATS_EN
    logic [15:0]          words_q [NUM_CH];
    logic [15:0]          words_d [NUM_CH];
    logic [15:0]          drops_q, drops_d;
    logic [NUM_CH*16-1:0] words_flat;

    // Counters saturate rather than wrap.
    always_comb begin
        words_flat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            words_d[i] = (ch_push[i] && (words_q[i] != 16'hFFFF)) ? words_q[i] + 16'd1 : words_q[i];
            words_flat[i*16 +: 16] = words_q[i];
        end
        drops_d = (overflow && (drops_q != 16'hFFFF)) ? drops_q + 16'd1 : drops_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drops_q <= '0;
            for (int i = 0; i < NUM_CH; i++) words_q[i] <= '0;
        end else begin
            drops_q <= drops_d;
            for (int i = 0; i < NUM_CH; i++) words_q[i] <= words_d[i];
        end
    end

    assign bus.stat_words = words_flat;
    assign bus.stat_drops = drops_q;
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_full_logic_nch.sv
// Bench for full_logic_nch: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based model of the routing rules.
module tb_full_logic_nch;
    localparam int DW = 6, AW = 2, NC = 4, DEPTH = 4, SEL = 4;
    localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    full_logic_nch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) bif ();
    full_logic_nch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .SEL_LSB(SEL)) dut (
        .clk(clk), .reset(reset), .bus(bif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int              mode, thr_main, thr_ch, m_drops;
    logic [DW-1:0]   ing [$];
    logic [DW-1:0]   chq [NC][$];
    logic [DW-1:0]   m_dout [NC];
    logic [NC-1:0]   m_valid, m_err;
    int              m_words [NC];

    function automatic int clamp(input int v);
        return ((v == 0) || (v > DEPTH)) ? DEPTH : v;
    endfunction

    task automatic model_reset();
        mode = M_RESET; thr_main = DEPTH; thr_ch = DEPTH; m_drops = 0;
        ing.delete();
        for (int i = 0; i < NC; i++) begin
            chq[i].delete(); m_dout[i] = '0; m_words[i] = 0;
        end
        m_valid = '0; m_err = '0;
    endtask

    task automatic model_step();
        logic [NC-1:0] p;
        bit busy, xfer, acc, ovf;
        int t;
        p = bif.pop; busy = 0; xfer = 0; acc = 0; ovf = 0; t = 0;
        m_valid = '0;
        if (mode == M_RESET) begin
            mode = M_INIT;
            return;
        end
        busy = (ing.size() > 0);
        for (int i = 0; i < NC; i++) if (chq[i].size() > 0) busy = 1;
        if (mode == M_ACTIVE && ing.size() > 0) begin
            t = int'(ing[0][SEL +: 2]);
            xfer = (chq[t].size() < thr_ch);
        end
        if ((mode == M_IDLE || mode == M_ACTIVE) && bif.wr_enable) begin
            if (ing.size() < DEPTH || xfer) acc = 1; else ovf = 1;
        end
        for (int i = 0; i < NC; i++) begin
            if (p[i]) begin
                if (chq[i].size() > 0) begin
                    m_dout[i] = chq[i].pop_front();
                    m_valid[i] = 1'b1;
                end else begin
                    m_err[i] = 1'b1;
                end
            end
        end
        if (xfer) begin
            chq[t].push_back(ing.pop_front());
            if (m_words[t] < 65535) m_words[t]++;
        end
        if (acc) ing.push_back(bif.data_in);
        if (ovf && m_drops < 65535) m_drops++;
        case (mode)
            M_INIT: begin
                if (bif.init) begin
                    thr_main = clamp(int'(bif.umbral_main));
                    thr_ch   = clamp(int'(bif.umbral_ch));
                end else mode = M_IDLE;
            end
            M_IDLE, M_ACTIVE: begin
                if (ovf)           mode = M_ERROR;
                else if (bif.init) mode = M_INIT;
                else               mode = (busy || acc) ? M_ACTIVE : M_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        logic [NC*DW-1:0] ed;
        logic [NC-1:0]    ee;
        logic [63:0]      ew;
        ed = '0; ee = '0; ew = '0;
        for (int i = 0; i < NC; i++) begin
            ed[i*DW +: DW] = m_dout[i];
            ee[i] = (chq[i].size() == 0);
            ew[i*16 +: 16] = 16'(m_words[i]);
        end
        check("data_out", 64'(bif.data_out), 64'(ed));
        check("valid_out", 64'(bif.valid_out), 64'(m_valid));
        check("empty_ch", 64'(bif.empty_ch), 64'(ee));
        check("error_ch", 64'(bif.error_ch), 64'(m_err));
        check("almost_full", 64'(bif.main_almost_full), 64'(ing.size() >= thr_main));
        check("status", 64'({bif.idle_out, bif.active_out, bif.error_out}),
              64'({mode == M_IDLE, mode == M_ACTIVE, mode == M_ERROR}));
`ifdef FULL_LOGIC_STATS_EN
        check("stat_words", 64'(bif.stat_words), ew);
        check("stat_drops", 64'(bif.stat_drops), 64'(m_drops));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (4) cycle();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!bif.idle_out && k < 20) begin
            cycle();
            k++;
        end
        check("idle_wait", 64'(bif.idle_out), 64'(1));
    endtask

    logic [DW-1:0] rw [4];
    logic [DW-1:0] sw [3];
    int wr_pct;

    initial begin
        rw = '{6'b000001, 6'b010010, 6'b100011, 6'b110100};
        sw = '{6'b010101, 6'b010110, 6'b010111};
        bif.init = 1'b0; bif.wr_enable = 1'b0; bif.data_in = '0;
        bif.umbral_main = '0; bif.umbral_ch = '0; bif.pop = '0;
        model_reset();
        #2;
        do_reset();
        check("reset_status", 64'({bif.idle_out, bif.active_out, bif.error_out}), 64'(0));
        check("reset_data", 64'(bif.data_out), 64'(0));

        // reset release with init held: RESET -> INIT, latch, then IDLE
        bif.init = 1'b1; bif.umbral_main = 3'd3; bif.umbral_ch = 3'd2; reset = 1'b1;
        cycle(); cycle();
        bif.init = 1'b0;
        cycle();
        check("idle_after_init", 64'(bif.idle_out), 64'(1));

        // one word per channel
        for (int i = 0; i < 4; i++) begin
            bif.wr_enable = 1'b1; bif.data_in = rw[i];
            cycle();
        end
        bif.wr_enable = 1'b0;
        repeat (2) cycle();
        check("route_empty", 64'(bif.empty_ch), 64'(0));
`ifdef FULL_LOGIC_STATS_EN
        check("route_stats", 64'(bif.stat_words), {16'd1, 16'd1, 16'd1, 16'd1});
`endif
        bif.pop = 4'b1111;
        cycle();
        check("route_valid", 64'(bif.valid_out), 64'(4'b1111));
        check("route_data", 64'(bif.data_out), 64'({rw[3], rw[2], rw[1], rw[0]}));
        bif.pop = '0;
        wait_idle();

        // head-of-line stall at channel threshold 2
        for (int i = 0; i < 3; i++) begin
            bif.wr_enable = 1'b1; bif.data_in = sw[i];
            cycle();
        end
        bif.wr_enable = 1'b0;
        repeat (4) cycle();
        check("stall_empty", 64'(bif.empty_ch), 64'(4'b1101));
        for (int i = 0; i < 3; i++) begin
            bif.pop = 4'b0010;
            cycle();
            check("stall_pop_valid", 64'(bif.valid_out), 64'(4'b0010));
            check("stall_pop_data", 64'(bif.data_out[DW +: DW]), 64'(sw[i]));
            bif.pop = '0;
            repeat (2) cycle();
        end
        wait_idle();

        // overflow with channel threshold 1
        bif.init = 1'b1; bif.umbral_main = 3'd3; bif.umbral_ch = 3'd1;
        cycle(); cycle();
        bif.init = 1'b0;
        cycle();
        for (int i = 0; i < 8; i++) begin
            bif.wr_enable = 1'b1; bif.data_in = 6'(i);
            cycle();
        end
        bif.wr_enable = 1'b0;
        check("ovf_error_out", 64'(bif.error_out), 64'(1));
        check("ovf_almost_full", 64'(bif.main_almost_full), 64'(1));
`ifdef FULL_LOGIC_STATS_EN
        check("ovf_drops_nonzero", 64'(bif.stat_drops != 16'd0), 64'(1));
`endif

        // underflow on empty channel 2
        bif.pop = 4'b0100;
        cycle();
        bif.pop = '0;
        cycle();
        check("udf_error_ch", 64'(bif.error_ch), 64'(4'b0100));
        check("udf_state", 64'(bif.error_out), 64'(1));
        check("udf_hold", 64'(bif.data_out[2*DW +: DW]), 64'(rw[2]));

        do_reset();
        check("reset_clears_err", 64'({bif.error_out, bif.error_ch}), 64'(0));

        // randomized traffic
        for (int ep = 0; ep < 10; ep++) begin
            bif.init = 1'b1;
            bif.umbral_main = 3'($urandom_range(0, 7));
            bif.umbral_ch = 3'($urandom_range(0, 7));
            reset = 1'b1;
            cycle(); cycle();
            bif.init = 1'b0;
            wr_pct = int'($urandom_range(20, 70));
            for (int c = 0; c < 250; c++) begin
                bif.wr_enable = (int'($urandom_range(0, 99)) < wr_pct);
                bif.data_in = 6'($urandom);
                bif.pop = 4'($urandom & $urandom);
                bif.init = ($urandom_range(0, 63) == 0);
                bif.umbral_main = 3'($urandom_range(0, 7));
                bif.umbral_ch = 3'($urandom_range(0, 7));
                cycle();
            end
            bif.wr_enable = 1'b0; bif.pop = '0; bif.init = 1'b0;
            do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/full_logic_nch.md
Name: full_logic_nch

Overview:
- Parametrised successor of the two-destination full_logic datapath.
- One ingress FIFO feeds NUM_CH destination FIFOs. Routing uses a selector field in each word.
- Shared control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) with programmable almost-full thresholds, per-channel pop/empty/error and status flags.
- Sits between the PCIe transmission-layer word source and the per-lane consumers.

Parameters:
- DATA_WIDTH, 6, word width.
- ADDR_WIDTH, 2, log2 of every FIFO depth (depth = 2**ADDR_WIDTH).
- NUM_CH, 4, number of destination channels (power of two, ≥2).
- SEL_LSB, 4, LSB of the route field in data_in. Route field width CH_BITS = log2(NUM_CH); SEL_LSB+CH_BITS ≤ DATA_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  enter/stay in INIT, latch thresholds.
- wr_enable  in  1  push data_in into ingress FIFO.
- data_in  in  DATA_WIDTH  write word.
- umbral_main  in  ADDR_WIDTH+1  ingress almost-full threshold.
- umbral_ch  in  ADDR_WIDTH+1  destination almost-full threshold, shared by all channels.
- pop  in  NUM_CH  per-channel pop request.
- data_out  out  NUM_CH*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- valid_out  out  NUM_CH  data_out slice i updated this cycle.
- empty_ch  out  NUM_CH  destination FIFO empty.
- error_ch  out  NUM_CH  sticky underflow flag per channel.
- main_almost_full  out  1  ingress count ≥ latched umbral_main (backpressure hint).
- idle_out, active_out, error_out  out  1 each  FSM status, one-hot.

Behaviour:
- Reset (reset=0, async):
  - All FIFOs empty.
  - data_out=0, valid_out=0, error_ch=0, main_almost_full=0.
  - Latched thresholds = 2**ADDR_WIDTH.
  - State RESET; all status outputs 0.
- States and transitions:
  - RESET → INIT on the first clk edge with reset=1.
  - INIT: thresholds latched every cycle while init=1.
    - init=0 → IDLE.
  - IDLE: all FIFOs empty.
    - Any FIFO non-empty → ACTIVE.
    - init=1 → INIT.
  - ACTIVE: any FIFO non-empty.
    - All empty → IDLE.
    - init=1 → INIT, FIFO contents kept.
  - ERROR: left only by reset.
  - Ingress overflow from IDLE/ACTIVE → ERROR; takes priority over init.
- Threshold latching: value 0 or value > depth is latched as depth.
- Ingress push:
  - Accepted in IDLE/ACTIVE when not full, or when full but a transfer pops the same cycle.
  - Full with no simultaneous pop → word dropped, state → ERROR next edge.
  - Push ignored in RESET/INIT/ERROR.
- Transfer (ingress → channel):
  - At most one word per cycle, only in ACTIVE.
  - Condition: ingress non-empty and target channel count < latched umbral_ch.
  - Target = head[SEL_LSB +: CH_BITS].
  - Strict head-of-line: a blocked head stalls all channels.
  - A word pushed into empty ingress is transferable the following cycle.
  - A destination FIFO cannot overflow by construction.
- Channel pop:
  - pop[i] with channel non-empty: head appears on data_out slice i and valid_out[i]=1 on the next cycle (1-cycle latency).
  - Otherwise data_out holds its value and valid_out[i]=0.
  - Pop works in every state except RESET.
  - Transfer and pop on the same channel in one cycle both occur; count unchanged.
- Underflow: pop[i] while empty_ch[i]=1 sets error_ch[i] (sticky until reset). FSM state unchanged.
- Status and count:
  - Status outputs registered from state: idle_out in IDLE, active_out in ACTIVE, error_out in ERROR.
  - main_almost_full is combinational from count and latched threshold.
  - Counts are ADDR_WIDTH+1 bits; read/write pointers wrap modulo depth.
- Reset mid-operation: reset=0 clears everything immediately regardless of state.

Optional Feature:
- Macro: FULL_LOGIC_STATS_EN.
- Defined:
  - Extra output stat_words  out  NUM_CH*16: per-channel count of words transferred in, saturating at 16'hFFFF.
  - Extra output stat_drops  out  16: dropped ingress pushes, saturating.
  - Both cleared by reset only.
- Undefined: ports and counters absent; no other behavioural change.

Decomposition:
- Package full_logic_pkg:
  - FSM state enum: RESET, INIT, IDLE, ACTIVE, ERROR.
  - clog2 helper for CH_BITS.
  - Threshold clamp function.
- Sub-module fifo_sync, instantiated NUM_CH+1 times:
  - Parameters DATA_WIDTH, ADDR_WIDTH.
  - push/pop, registered read data, count, empty/full.
- Routing, FSM, thresholds and status logic live in full_logic_nch.

Test Plan:
- Reset and init: reset=0 4 cycles → all outputs 0. Then reset=1 with init=1, umbral_main=3, umbral_ch=2 → INIT. init=0 → idle_out=1 after 1 cycle.
- Routing (NUM_CH=4, SEL_LSB=4):
  - Push 6'b000001, 6'b010010, 6'b100011, 6'b110100 → one word lands in each of channels 0–3.
  - pop=4'b1111 → next cycle valid_out=4'b1111 with matching data slices.
  - Then idle_out=1.
- Threshold stall: umbral_ch=2, push 3 words routed to channel 1 with no pops → channel 1 holds 2 and ingress holds 1. pop[1] once → third word transfers.
- Overflow: umbral_ch=1, stream 8 words to one channel with no pops → ingress fills (depth 4), next push → error_out=1. Further pushes ignored; only reset clears error_out.
- Underflow: pop[2] on empty channel → error_ch=4'b0100, state unchanged, data_out slice 2 holds its value.
- With FULL_LOGIC_STATS_EN: after the routing scenario stat_words = 1 per channel. After the overflow scenario stat_drops ≥ 1.
